// File: rtl/seg7_scan_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_if                                                  |
// | Brief    : Scanned 7-segment bus plus decoded-word outputs.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   err_mask;
  logic                frame_valid;
  logic                scan_err;

  modport master (
    output seg_n, an_n,
    input  bcd_out, blank_mask, err_mask, frame_valid, scan_err
  );

  modport slave (
    input  seg_n, an_n,
    output bcd_out, blank_mask, err_mask, frame_valid, scan_err
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_to_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_to_bcd                                              |
// | Brief    : Samples a scanned 7-segment display and rebuilds a BCD word.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_scan_to_bcd #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  // The incoming value is compared against the held sample, so the edge that
  // registers the STABLE_CYCLES-th identical sample sees cnt == STABLE_CYCLES-2.
  localparam logic [7:0] c_trig = 8'(STABLE_CYCLES - 2);

  state_t              r_state;
  state_t              w_state_next;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_next;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_sh_bcd;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [DIGITS-1:0]   r_sh_err;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_blank;
  logic [DIGITS-1:0]   r_err;
  logic                r_fv;
  logic                r_serr;

  logic                w_same;
  logic [DIGITS-1:0]   w_act;
  logic                w_onehot;
  logic                w_capture;
  logic                w_scan_err;
  logic [DIGITS-1:0]   w_seen_cap;
  logic [3:0]          w_nib;
  logic                w_is_blank;
  logic                w_is_err;

  assign w_same   = (bus.seg_n == r_seg) && (bus.an_n == r_an);
  assign w_act    = ~r_an;
  assign w_onehot = (w_act != '0) && ((w_act & (w_act - 1'b1)) == '0);

  always_comb begin
    w_nib      = 4'hE;
    w_is_blank = 1'b0;
    w_is_err   = 1'b0;
    case (r_seg)
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b1111111: begin
        w_nib      = 4'hF;
        w_is_blank = 1'b1;
      end
      default:    w_is_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SETTLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_scan_err   = 1'b0;
    case (r_state)
      SETTLE: begin
        if (!w_same) begin
          w_cnt_next = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
          if (r_cnt == c_trig) begin
            w_state_next = HOLD;
            if (w_act == '0) begin
              w_capture = 1'b0;
            end else if (w_onehot) begin
              w_capture = 1'b1;
            end else begin
              w_scan_err = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (!w_same) begin
          w_cnt_next   = 8'd0;
          w_state_next = SETTLE;
        end
      end
      default: begin
        w_cnt_next   = 8'd0;
        w_state_next = SETTLE;
      end
    endcase
  end

  assign w_seen_cap = w_capture ? w_act : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg      <= 7'h7F;
      r_an       <= '1;
      r_seen     <= '0;
      r_sh_bcd   <= '0;
      r_sh_blank <= '0;
      r_sh_err   <= '0;
      r_bcd      <= '0;
      r_blank    <= '0;
      r_err      <= '0;
      r_fv       <= 1'b0;
      r_serr     <= 1'b0;
    end else begin
      r_seg  <= bus.seg_n;
      r_an   <= bus.an_n;
      r_serr <= w_scan_err;
      r_fv   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_capture && w_act[i]) begin
          r_sh_bcd[4*i +: 4] <= w_nib;
          r_sh_blank[i]      <= w_is_blank;
          r_sh_err[i]        <= w_is_err;
        end
      end
      // A capture on the publishing edge belongs to the next frame.
      if (&r_seen) begin
        r_bcd   <= r_sh_bcd;
        r_blank <= r_sh_blank;
        r_err   <= r_sh_err;
        r_fv    <= 1'b1;
        r_seen  <= w_seen_cap;
      end else begin
        r_seen  <= r_seen | w_seen_cap;
      end
    end
  end

  assign bus.bcd_out     = r_bcd;
  assign bus.blank_mask  = r_blank;
  assign bus.err_mask    = r_err;
  assign bus.frame_valid = r_fv;
  assign bus.scan_err    = r_serr;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_to_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_to_bcd                                           |
// | Brief    : Directed self-checking bench for seg7_scan_to_bcd.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_to_bcd;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PB = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   fv_cnt = 0;
  int   se_cnt = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(4)) bus ();

  seg7_scan_to_bcd #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_cnt++;
    if (bus.scan_err === 1'b1) se_cnt++;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int b_fv, b_se;
    bus.an_n  = 4'hF;
    bus.seg_n = PB;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (bus.bcd_out !== 16'h0000) begin fails++; $display("FAIL rst_bcd: got %h want 0000", bus.bcd_out); end
    tests++; if (bus.blank_mask !== 4'h0) begin fails++; $display("FAIL rst_blank: got %b want 0000", bus.blank_mask); end
    tests++; if (bus.err_mask !== 4'h0) begin fails++; $display("FAIL rst_err: got %b want 0000", bus.err_mask); end
    tests++; if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL rst_fv: got %b want 0", bus.frame_valid); end
    tests++; if (bus.scan_err !== 1'b0) begin fails++; $display("FAIL rst_serr: got %b want 0", bus.scan_err); end
    b_fv = fv_cnt;
    b_se = se_cnt;
    drive(4'hF, PB, 20);
    tests++; if (fv_cnt - b_fv !== 0) begin fails++; $display("FAIL idle_fv: got %0d pulses want 0", fv_cnt - b_fv); end
    tests++; if (se_cnt - b_se !== 0) begin fails++; $display("FAIL idle_serr: got %0d pulses want 0", se_cnt - b_se); end
  endtask

  task automatic test_frame();
    int b_fv;
    b_fv = fv_cnt;
    drive(4'b1110, P4, 6);
    drive(4'b1101, P3, 6);
    drive(4'b1011, P2, 6);
    drive(4'b0111, P1, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 1) begin fails++; $display("FAIL frame_fv: got %0d pulses want 1", fv_cnt - b_fv); end
    tests++; if (bus.bcd_out !== 16'h1234) begin fails++; $display("FAIL frame_bcd: got %h want 1234", bus.bcd_out); end
    tests++; if (bus.blank_mask !== 4'b0000) begin fails++; $display("FAIL frame_blank: got %b want 0000", bus.blank_mask); end
    tests++; if (bus.err_mask !== 4'b0000) begin fails++; $display("FAIL frame_err: got %b want 0000", bus.err_mask); end
  endtask

  task automatic test_short_glitch();
    int b_fv;
    b_fv = fv_cnt;
    drive(4'b1110, P4, 6);
    drive(4'b1101, P3, 6);
    drive(4'b1101, P7, 3);
    drive(4'b1011, P9, 3);
    drive(4'b1011, P5, 6);
    drive(4'b0111, P1, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 1) begin fails++; $display("FAIL glitch_fv: got %0d pulses want 1", fv_cnt - b_fv); end
    tests++; if (bus.bcd_out !== 16'h1534) begin fails++; $display("FAIL glitch_bcd: got %h want 1534", bus.bcd_out); end
  endtask

  task automatic test_blank_err();
    int b_fv;
    b_fv = fv_cnt;
    drive(4'b1110, P0, 6);
    drive(4'b1101, PB, 6);
    drive(4'b1011, P0, 6);
    drive(4'b0111, 7'b1110000, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 1) begin fails++; $display("FAIL be_fv: got %0d pulses want 1", fv_cnt - b_fv); end
    tests++; if (bus.bcd_out !== 16'hE0F0) begin fails++; $display("FAIL be_bcd: got %h want e0f0", bus.bcd_out); end
    tests++; if (bus.blank_mask !== 4'b0010) begin fails++; $display("FAIL be_blank: got %b want 0010", bus.blank_mask); end
    tests++; if (bus.err_mask !== 4'b1000) begin fails++; $display("FAIL be_err: got %b want 1000", bus.err_mask); end
  endtask

  task automatic test_scan_err();
    int b_fv, b_se;
    b_fv = fv_cnt;
    b_se = se_cnt;
    drive(4'b0011, P8, 6);
    drive(4'hF, PB, 4);
    tests++; if (se_cnt - b_se !== 1) begin fails++; $display("FAIL serr_pulse: got %0d pulses want 1", se_cnt - b_se); end
    drive(4'b1110, P1, 6);
    drive(4'b1101, P2, 6);
    drive(4'b1011, P3, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 0) begin fails++; $display("FAIL serr_nocap: got %0d pulses want 0", fv_cnt - b_fv); end
    drive(4'b0111, P4, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 1) begin fails++; $display("FAIL serr_fv: got %0d pulses want 1", fv_cnt - b_fv); end
    tests++; if (bus.bcd_out !== 16'h4321) begin fails++; $display("FAIL serr_bcd: got %h want 4321", bus.bcd_out); end
  endtask

  task automatic test_reset_mid();
    int b_fv;
    drive(4'b1110, P5, 6);
    drive(4'b1101, P5, 6);
    bus.an_n  = 4'hF;
    bus.seg_n = PB;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (bus.bcd_out !== 16'h0000) begin fails++; $display("FAIL mid_bcd: got %h want 0000", bus.bcd_out); end
    tests++; if (bus.blank_mask !== 4'h0) begin fails++; $display("FAIL mid_blank: got %b want 0000", bus.blank_mask); end
    tests++; if (bus.err_mask !== 4'h0) begin fails++; $display("FAIL mid_err: got %b want 0000", bus.err_mask); end
    b_fv = fv_cnt;
    drive(4'b1011, P9, 6);
    drive(4'b0111, P0, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 0) begin fails++; $display("FAIL mid_partial: got %0d pulses want 0", fv_cnt - b_fv); end
    drive(4'b1110, P7, 6);
    drive(4'b1101, P8, 6);
    drive(4'hF, PB, 4);
    tests++; if (fv_cnt - b_fv !== 1) begin fails++; $display("FAIL mid_fv: got %0d pulses want 1", fv_cnt - b_fv); end
    tests++; if (bus.bcd_out !== 16'h0987) begin fails++; $display("FAIL mid_final_bcd: got %h want 0987", bus.bcd_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end

  initial begin
    bus.an_n  = 4'hF;
    bus.seg_n = PB;
    test_reset();
    test_frame();
    test_short_glitch();
    test_blank_err();
    test_scan_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
